// File: rtl/chicken_judge_if.sv
// Request/result bundle between the game control FSM and chicken_judge.
interface chicken_judge_if;
    logic        start;
    logic [3:0]  num_players;
    logic [3:0]  seed;
    logic        req;
    logic [3:0]  card;
    logic        done;
    logic        go;
    logic        win;
    logic        err;
    logic        busy;
    logic [1:0]  cur_player;
    logic [19:0] pos_flat;

    modport master (
        output start, num_players, seed, req, card,
        input  done, go, win, err, busy, cur_player, pos_flat
    );

    modport slave (
        input  start, num_players, seed, req, card,
        output done, go, win, err, busy, cur_player, pos_flat
    );
endinterface

// File: rtl/chicken_judge.sv
// Game-rule responder: checks a revealed card against the tile ahead of the
// current chicken, moves it (hopping occupied tiles) and owns all board state.
module chicken_judge #(
    parameter int unsigned TRACK_LEN = 24,
    parameter int unsigned NUM_PIC   = 12
) (
    input  logic           clk,
    input  logic           rst,
    chicken_judge_if.slave bus
);
    localparam int unsigned POS_W     = 5;
    localparam int unsigned MAX_PLAY  = 4;
    localparam int unsigned SPACING   = TRACK_LEN / 4;
    localparam logic [POS_W-1:0] LAST_TILE = POS_W'(TRACK_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, HOP, DONE} state_t;
    state_t state, state_next;

    logic [POS_W-1:0] pos [MAX_PLAY];
    logic [POS_W-1:0] cand;
    logic [2:0]       count;
    logic [3:0]       seed_q;
    logic [3:0]       card_q;
    logic [1:0]       cur;
    logic             done, go, win, err, busy;

    logic [POS_W-1:0] cur_pos, step_pos;
    logic             card_bad, pic_hit, occupied;
    logic [1:0]       cur_next;

    function automatic logic [3:0] tile_pic(input logic [POS_W-1:0] i);
        return 4'((32'(i) * 32'd5 + 32'd3) % NUM_PIC);
    endfunction

    function automatic logic [3:0] card_pic(input logic [3:0] k, input logic [3:0] s);
        return 4'((32'(k) * 32'd7 + 32'(s)) % NUM_PIC);
    endfunction

    function automatic logic [POS_W-1:0] inc_pos(input logic [POS_W-1:0] p);
        return (p == LAST_TILE) ? '0 : p + POS_W'(1);
    endfunction

    // Match test and occupancy of the candidate tile by other active chickens.
    always_comb begin
        cur_pos  = pos[cur];
        step_pos = inc_pos(cur_pos);
        card_bad = card_q >= 4'(NUM_PIC);
        pic_hit  = card_pic(card_q, seed_q) == tile_pic(step_pos);
        occupied = 1'b0;
        for (int q = 0; q < int'(MAX_PLAY); q++) begin
            if (3'(q) < count && 2'(q) != cur && pos[q] == cand)
                occupied = 1'b1;
        end
        cur_next = (3'(cur) + 3'd1 >= count) ? 2'd0 : cur + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.start) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.req && !win) state_next = LOOKUP;
                LOOKUP:  state_next = (card_bad || !pic_hit) ? DONE : HOP;
                HOP:     if (!occupied) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Board state and result flags; results land together with the done strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 3'd1;
            seed_q <= '0;
            card_q <= '0;
            cand   <= '0;
            cur    <= '0;
            done   <= 1'b0;
            go     <= 1'b0;
            win    <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            for (int p = 0; p < int'(MAX_PLAY); p++) pos[p] <= POS_W'(32'(p) * SPACING);
        end else if (bus.start) begin
            if (bus.num_players == 4'd0)     count <= 3'd1;
            else if (bus.num_players > 4'd4) count <= 3'd4;
            else                             count <= 3'(bus.num_players);
            seed_q <= bus.seed % 4'(NUM_PIC);
            cur    <= '0;
            done   <= 1'b0;
            go     <= 1'b0;
            win    <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            for (int p = 0; p < int'(MAX_PLAY); p++) pos[p] <= POS_W'(32'(p) * SPACING);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req && !win) begin
                        card_q <= bus.card;
                        busy   <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (card_bad) begin
                        err  <= 1'b1;
                        go   <= 1'b0;
                        done <= 1'b1;
                    end else if (!pic_hit) begin
                        err  <= 1'b0;
                        go   <= 1'b0;
                        done <= 1'b1;
                        cur  <= cur_next;
                    end else begin
                        cand <= step_pos;
                    end
                end
                HOP: begin
                    if (occupied) begin
                        cand <= inc_pos(cand);
                    end else begin
                        pos[cur] <= cand;
                        go       <= 1'b1;
                        err      <= 1'b0;
                        done     <= 1'b1;
                        if (cand < cur_pos) win <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.done       = done;
    assign bus.go         = go;
    assign bus.win        = win;
    assign bus.err        = err;
    assign bus.busy       = busy;
    assign bus.cur_player = cur;
    assign bus.pos_flat   = {pos[3], pos[2], pos[1], pos[0]};
endmodule
